// File: rtl/reg_bank_rw_if.sv
// Bus bundle for the 32-entry register bank: one write port, two read ports.
// master: datapath side (drives enable, indices and write data; receives read data).
// slave:  register bank side (receives the request, returns ReadData1/ReadData2).
interface reg_bank_rw_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    modport master (
        output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        input  ReadData1, ReadData2
    );

    modport slave (
        input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
        output ReadData1, ReadData2
    );
endinterface

// File: rtl/reg_bank_rw.sv
// Purpose: 32x32 MIPS register bank, $zero hard-wired, $sp resets to SP_RESET.
// Latency: 1 cycle address-to-data on both read ports, write-first forwarding.
// Backpressure: none; the bank is always ready, inputs sampled on every edge.
// Ports: clk, reset (synchronous, active-high), bus (reg_bank_rw_if.slave):
//   RegWrite/WriteReg/WriteData write port, ReadReg1/2 -> ReadData1/2 read ports.
module reg_bank_rw #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_IDX   = 29,
    parameter int SP_RESET = 227,
    parameter int RA_IDX   = 31
) (
    input  logic          clk,
    input  logic          reset,
    reg_bank_rw_if.slave  bus
);
    localparam int N_REGS = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] SP_RST_VAL = DATA_W'(SP_RESET);

    // The special indices must land inside the bank and must not alias $zero.
    if (SP_IDX <= 0 || SP_IDX >= N_REGS || RA_IDX <= 0 || RA_IDX >= N_REGS) begin : g_bad_idx
        $error("reg_bank_rw: SP_IDX/RA_IDX outside 1..N_REGS-1");
    end

    logic [DATA_W-1:0] regs_q [N_REGS];
    logic [DATA_W-1:0] regs_d [N_REGS];
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;

    logic wr_en;
    assign wr_en = bus.RegWrite && (bus.WriteReg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.WriteReg] = bus.WriteData;
        end
        // Reading from the post-write view gives write-first forwarding for free;
        // index 0 is forced to zero so it can never pick up a forwarded value.
        rd1_d = (bus.ReadReg1 == '0) ? '0 : regs_d[bus.ReadReg1];
        rd2_d = (bus.ReadReg2 == '0) ? '0 : regs_d[bus.ReadReg2];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs_q[i] <= (i == SP_IDX) ? SP_RST_VAL : '0;
            end
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            regs_q <= regs_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
        end
    end

    assign bus.ReadData1 = rd1_q;
    assign bus.ReadData2 = rd2_q;
endmodule

// File: tb/tb_reg_bank_rw.sv
module tb_reg_bank_rw;
    logic clk;
    logic reset;

    reg_bank_rw_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_bank_rw #(
        .DATA_W(32), .ADDR_W(5), .SP_IDX(29), .SP_RESET(227), .RA_IDX(31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            edge_no;
        logic [31:0]   e1;
        logic [31:0]   e2;
        logic [79:0]   name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m;
    int          edge_cnt = 0;
    int          tests    = 0;
    int          fails    = 0;
    bit          started  = 1'b0;
    logic [31:0] s1, s2;

    // Drive one cycle of inputs and queue the outputs expected after the edge
    // that samples them. Inputs change 3 time units after each rising edge.
    task automatic step(input bit rst, input bit we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [79:0] nm);
        exp_t e;
        reset         = rst;
        bus.RegWrite  = we;
        bus.WriteReg  = wa;
        bus.WriteData = wd;
        bus.ReadReg1  = r1;
        bus.ReadReg2  = r2;
        e.edge_no = edge_cnt + 1;
        e.e1      = e1;
        e.e2      = e2;
        e.name    = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #3;
    endtask

    // Monitor: sample just after each edge, retire expectations due at this edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            edge_cnt++;
            s1 = bus.ReadData1;
            s2 = bus.ReadData2;
            started = 1'b1;
            while (sb_q.size() > 0 && sb_q[0].edge_no <= edge_cnt) begin
                m = sb_q.pop_front();
                tests++;
                if (s1 !== m.e1) begin
                    fails++;
                    $display("FAIL %0s rd1: got %h expected %h (edge %0d)", m.name, s1, m.e1, edge_cnt);
                end
                tests++;
                if (s2 !== m.e2) begin
                    fails++;
                    $display("FAIL %0s rd2: got %h expected %h (edge %0d)", m.name, s2, m.e2, edge_cnt);
                end
            end
        end
    end

    // Outputs must not move between edges even though inputs change mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                tests++;
                if (bus.ReadData1 !== s1 || bus.ReadData2 !== s2) begin
                    fails++;
                    $display("FAIL hold: got %h/%h expected %h/%h (edge %0d)",
                             bus.ReadData1, bus.ReadData2, s1, s2, edge_cnt);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.RegWrite = 1'b0; bus.WriteReg = '0; bus.WriteData = '0;
        bus.ReadReg1 = '0;   bus.ReadReg2 = '0;

        //     rst we  wa     wd            r1     r2     exp1          exp2
        step(1, 0, 5'd0,  32'h0,        5'd29, 5'd5,  32'h0,        32'h0,        "rst");
        step(0, 0, 5'd0,  32'h0,        5'd29, 5'd5,  32'd227,      32'h0,        "sp_rst");
        step(0, 1, 5'd8,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0,        "wr8");
        step(0, 0, 5'd0,  32'h0,        5'd8,  5'd9,  32'hDEADBEEF, 32'h0,        "wr_rd");
        step(0, 1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd8,  32'h0,        32'hDEADBEEF, "zero_fwd");
        step(0, 0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        "zero_rd");
        step(0, 1, 5'd31, 32'h11,       5'd31, 5'd0,  32'h11,       32'h0,        "ra_wr");
        step(0, 0, 5'd0,  32'h0,        5'd31, 5'd31, 32'h11,       32'h11,       "ra_rd");
        step(0, 1, 5'd31, 32'h00400010, 5'd31, 5'd31, 32'h00400010, 32'h00400010, "fwd");
        step(0, 0, 5'd0,  32'h0,        5'd31, 5'd29, 32'h00400010, 32'd227,      "fwd_after");
        step(0, 1, 5'd29, 32'h0000FFF0, 5'd8,  5'd0,  32'hDEADBEEF, 32'h0,        "sp_wr");
        step(0, 0, 5'd0,  32'h0,        5'd29, 5'd8,  32'h0000FFF0, 32'hDEADBEEF, "sp_rd");
        step(1, 1, 5'd29, 32'h1234,     5'd29, 5'd29, 32'h0,        32'h0,        "rst_pri");
        step(0, 0, 5'd0,  32'h0,        5'd29, 5'd8,  32'd227,      32'h0,        "rst_sp");
        step(0, 0, 5'd0,  32'h0,        5'd31, 5'd0,  32'h0,        32'h0,        "rst_ra");
        step(0, 1, 5'd2,  32'd5,        5'd3,  5'd2,  32'h0,        32'd5,        "b2b_a");
        step(0, 1, 5'd3,  32'd7,        5'd2,  5'd3,  32'd5,        32'd7,        "b2b_b");
        step(0, 1, 5'd2,  32'd9,        5'd2,  5'd3,  32'd9,        32'd7,        "b2b_c");
        step(0, 0, 5'd0,  32'h0,        5'd2,  5'd3,  32'd9,        32'd7,        "b2b");

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
